// File: rtl/io_ctrl_pkg.sv
// rtl/io_ctrl_pkg.sv - shared constants and interrupt FSM state type for the io port controller
package io_ctrl_pkg;

  localparam int DEFAULT_DEPTH       = 4;
  localparam int DEFAULT_INT_HOLDOFF = 8;
  localparam int DATA_W              = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } int_state_t;

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - 16-bit synchronous FIFO with wrapping pointers; head is the raw entry at the read pointer
module io_fifo
  import io_ctrl_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop on empty is ignored; a push on full only succeeds if a pop frees the slot this cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array carries no reset; entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/io_port_controller.sv
// rtl/io_port_controller.sv - processor IO port glue: input/output FIFOs, sticky overflow flag, optional interrupt FSM (IO_CTRL_INT_EN)
module io_port_controller
  import io_ctrl_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int INT_HOLDOFF = DEFAULT_INT_HOLDOFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ext_in_data,
  input  logic        ext_in_valid,
  output logic        ext_in_ready,
  output logic [15:0] in_port,
  input  logic        in_rd,
  input  logic [15:0] out_port,
  input  logic        out_wr,
  output logic [15:0] ext_out_data,
  output logic        ext_out_valid,
  input  logic        ext_out_ready,
  output logic        int_req,
  output logic        out_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || INT_HOLDOFF < 1) begin : g_param_check
    $error("io_port_controller: DEPTH must be a power of two >= 2 and INT_HOLDOFF >= 1");
  end

  logic          in_push;
  logic          in_full;
  logic          in_empty;
  logic [CW-1:0] in_count;
  logic [15:0]   in_head;

  logic          out_pop;
  logic          out_full;
  logic          out_empty;
  logic [CW-1:0] out_count;
  logic [15:0]   out_head;

  // Ready depends on occupancy only, so it never combinationally follows in_rd.
  assign ext_in_ready = (in_count != CW'(DEPTH));
  assign in_push      = ext_in_valid & ~in_full;
  assign in_port      = in_empty ? 16'h0000 : in_head;

  assign ext_out_valid = (out_count != '0);
  assign ext_out_data  = out_empty ? 16'h0000 : out_head;
  assign out_pop       = ext_out_valid & ext_out_ready;

  io_fifo #(.DEPTH(DEPTH)) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_push),
    .push_data (ext_in_data),
    .pop       (in_rd),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count),
    .head      (in_head)
  );

  io_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (out_wr),
    .push_data (out_port),
    .pop       (out_pop),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count),
    .head      (out_head)
  );

  // Sticky flag: an OUT word arrived while the output FIFO was full and nothing drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_overflow <= 1'b0;
    end else if (out_wr && out_full && !out_pop) begin
      out_overflow <= 1'b1;
    end
  end

`ifdef IO_CTRL_INT_EN
  localparam int HW = (INT_HOLDOFF > 1) ? $clog2(INT_HOLDOFF) : 1;

  int_state_t    state;
  logic [HW-1:0] holdoff_cnt;

  // Interrupt FSM: one-cycle pulse while input data waits, then INT_HOLDOFF quiet cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      holdoff_cnt <= '0;
      int_req     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!in_empty) begin
            state   <= PULSE;
            int_req <= 1'b1;
          end
        end
        PULSE: begin
          state       <= HOLDOFF;
          holdoff_cnt <= HW'(INT_HOLDOFF - 1);
          int_req     <= 1'b0;
        end
        HOLDOFF: begin
          if (holdoff_cnt <= HW'(1)) begin
            holdoff_cnt <= '0;
            state       <= IDLE;
          end else begin
            holdoff_cnt <= holdoff_cnt - HW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end
`else
  assign int_req = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_controller.sv
// tb/tb_io_port_controller.sv - directed self-checking bench for io_port_controller (DEPTH=4, INT_HOLDOFF=8)
module tb_io_port_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic [15:0] in_port;
  logic        in_rd;
  logic [15:0] out_port;
  logic        out_wr;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic        int_req;
  logic        out_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_port_controller #(.DEPTH(4), .INT_HOLDOFF(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .in_port       (in_port),
    .in_rd         (in_rd),
    .out_port      (out_port),
    .out_wr        (out_wr),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .int_req       (int_req),
    .out_overflow  (out_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset         = 1'b0;
    ext_in_data   = 16'h0000;
    ext_in_valid  = 1'b0;
    in_rd         = 1'b0;
    out_port      = 16'h0000;
    out_wr        = 1'b0;
    ext_out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int: got %b exp 0", int_req); end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", out_overflow); end
    checks++; if (ext_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", ext_out_valid); end
    checks++; if (in_port !== 16'h0000) begin errors++; $display("FAIL reset_in_port: got %h exp 0000", in_port); end
    checks++; if (ext_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", ext_in_ready); end
  endtask

  task automatic test_in_fifo();
    apply_reset();
    ext_in_valid = 1'b1; ext_in_data = 16'hA5A5;
    tick();
    checks++; if (in_port !== 16'hA5A5) begin errors++; $display("FAIL in_first: got %h exp a5a5", in_port); end
    ext_in_data = 16'h1234;
    tick();
    ext_in_valid = 1'b0;
    checks++; if (in_port !== 16'hA5A5) begin errors++; $display("FAIL in_head_held: got %h exp a5a5", in_port); end
    in_rd = 1'b1;
    tick();
    checks++; if (in_port !== 16'h1234) begin errors++; $display("FAIL in_second: got %h exp 1234", in_port); end
    tick();
    checks++; if (in_port !== 16'h0000) begin errors++; $display("FAIL in_empty_zero: got %h exp 0000", in_port); end
    tick();
    in_rd = 1'b0;
    checks++; if (in_port !== 16'h0000 || ext_in_ready !== 1'b1) begin errors++; $display("FAIL in_underflow: got port %h ready %b exp 0000 1", in_port, ext_in_ready); end
    ext_in_valid = 1'b1; ext_in_data = 16'hBEEF;
    tick();
    ext_in_valid = 1'b0;
    checks++; if (in_port !== 16'hBEEF) begin errors++; $display("FAIL in_after_underflow: got %h exp beef", in_port); end
    in_rd = 1'b1;
    tick();
    in_rd = 1'b0;
    checks++; if (in_port !== 16'h0000) begin errors++; $display("FAIL in_drain_one: got %h exp 0000", in_port); end
  endtask

  task automatic test_in_full();
    apply_reset();
    ext_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ext_in_data = 16'(i);
      tick();
    end
    ext_in_data = 16'h0005;
    checks++; if (ext_in_ready !== 1'b0 || in_port !== 16'h0001) begin errors++; $display("FAIL full_ready: got ready %b port %h exp 0 0001", ext_in_ready, in_port); end
    tick();
    checks++; if (ext_in_ready !== 1'b0 || in_port !== 16'h0001) begin errors++; $display("FAIL full_held: got ready %b port %h exp 0 0001", ext_in_ready, in_port); end
    in_rd = 1'b1;
    tick();
    in_rd = 1'b0;
    checks++; if (ext_in_ready !== 1'b1 || in_port !== 16'h0002) begin errors++; $display("FAIL full_pop: got ready %b port %h exp 1 0002", ext_in_ready, in_port); end
    tick();
    ext_in_valid = 1'b0;
    checks++; if (ext_in_ready !== 1'b0) begin errors++; $display("FAIL full_refill: got ready %b exp 0", ext_in_ready); end
    for (int i = 2; i <= 5; i++) begin
      checks++; if (in_port !== 16'(i)) begin errors++; $display("FAIL full_drain: got %h exp %h", in_port, 16'(i)); end
      in_rd = 1'b1;
      tick();
      in_rd = 1'b0;
    end
    checks++; if (in_port !== 16'h0000 || ext_in_ready !== 1'b1) begin errors++; $display("FAIL full_drained: got port %h ready %b exp 0000 1", in_port, ext_in_ready); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ext_in_valid = 1'b1;
    ext_in_data = 16'h0010; tick();
    ext_in_data = 16'h0011; tick();
    ext_in_data = 16'h0012; in_rd = 1'b1; tick();
    in_rd = 1'b0;
    checks++; if (in_port !== 16'h0011) begin errors++; $display("FAIL b2b_head: got %h exp 0011", in_port); end
    ext_in_data = 16'h0013; tick();
    checks++; if (ext_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_count3: got ready %b exp 1", ext_in_ready); end
    ext_in_data = 16'h0014; tick();
    ext_in_valid = 1'b0;
    checks++; if (ext_in_ready !== 1'b0) begin errors++; $display("FAIL b2b_count4: got ready %b exp 0", ext_in_ready); end
    for (int i = 16'h11; i <= 16'h14; i++) begin
      checks++; if (in_port !== 16'(i)) begin errors++; $display("FAIL b2b_drain: got %h exp %h", in_port, 16'(i)); end
      in_rd = 1'b1;
      tick();
      in_rd = 1'b0;
    end
  endtask

  task automatic test_out_fifo();
    apply_reset();
    out_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      out_port = 16'h0100 + 16'(i);
      tick();
    end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL out_no_ovf: got %b exp 0", out_overflow); end
    out_port = 16'h0104;
    tick();
    out_wr = 1'b0;
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL out_ovf: got %b exp 1", out_overflow); end
    ext_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ext_out_valid !== 1'b1 || ext_out_data !== 16'h0100 + 16'(i)) begin errors++; $display("FAIL out_drain: got valid %b data %h exp 1 %h", ext_out_valid, ext_out_data, 16'h0100 + 16'(i)); end
      tick();
    end
    ext_out_ready = 1'b0;
    checks++; if (ext_out_valid !== 1'b0 || ext_out_data !== 16'h0000) begin errors++; $display("FAIL out_empty: got valid %b data %h exp 0 0000", ext_out_valid, ext_out_data); end
    checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL out_ovf_sticky: got %b exp 1", out_overflow); end
  endtask

  task automatic test_out_simul();
    apply_reset();
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL simul_reset_ovf: got %b exp 0", out_overflow); end
    out_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      out_port = 16'h0200 + 16'(i);
      tick();
    end
    out_port = 16'h0204; ext_out_ready = 1'b1;
    tick();
    out_wr = 1'b0;
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b exp 0", out_overflow); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (ext_out_data !== 16'h0200 + 16'(i)) begin errors++; $display("FAIL simul_drain: got %h exp %h", ext_out_data, 16'h0200 + 16'(i)); end
      tick();
    end
    ext_out_ready = 1'b0;
    checks++; if (ext_out_valid !== 1'b0) begin errors++; $display("FAIL simul_empty: got %b exp 0", ext_out_valid); end
  endtask

  task automatic test_interrupt();
    apply_reset();
    ext_in_valid = 1'b1; ext_in_data = 16'h0055;
    tick();
    ext_in_valid = 1'b0;
`ifdef IO_CTRL_INT_EN
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL int_before: got %b exp 0", int_req); end
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL int_first: got %b exp 1", int_req); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL int_holdoff: cycle %0d got %b exp 0", i, int_req); end
    end
    tick();
    checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL int_second: got %b exp 1", int_req); end
    in_rd = 1'b1;
    tick();
    in_rd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL int_quiet: cycle %0d got %b exp 0", i, int_req); end
      tick();
    end
`else
    for (int i = 0; i < 20; i++) begin
      checks++; if (int_req !== 1'b0 || in_port !== 16'h0055) begin errors++; $display("FAIL int_disabled: cycle %0d got int %b port %h exp 0 0055", i, int_req, in_port); end
      tick();
    end
    in_rd = 1'b1;
    tick();
    in_rd = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ext_in_valid = 1'b1;
    ext_in_data = 16'hAAAA; tick();
    ext_in_data = 16'hBBBB; tick();
    ext_in_valid = 1'b0;
    out_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      out_port = 16'h0300 + 16'(i);
      tick();
    end
    checks++; if (out_overflow !== 1'b1 || in_port !== 16'hAAAA) begin errors++; $display("FAIL mid_setup: got ovf %b port %h exp 1 aaaa", out_overflow, in_port); end
    reset = 1'b1; ext_in_valid = 1'b1; ext_in_data = 16'hCCCC; in_rd = 1'b1; ext_out_ready = 1'b1;
    tick();
    idle_inputs();
    checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL mid_int: got %b exp 0", int_req); end
    checks++; if (ext_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b exp 0", ext_out_valid); end
    checks++; if (in_port !== 16'h0000) begin errors++; $display("FAIL mid_in_port: got %h exp 0000", in_port); end
    checks++; if (ext_in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b exp 1", ext_in_ready); end
    checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b exp 0", out_overflow); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (int_req !== 1'b0 || ext_out_valid !== 1'b0) begin errors++; $display("FAIL mid_residual: cycle %0d got int %b valid %b exp 0 0", i, int_req, ext_out_valid); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_in_fifo();
    test_in_full();
    test_back_to_back();
    test_out_fifo();
    test_out_simul();
    test_interrupt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
